// File: rtl/float_to_ieee_conv_pkg.sv
// Shared types and constants for the internal-float to IEEE-754 output stage.
// Default internal format: 1 sign | 4 exponent | 20 mantissa.
package float_to_ieee_conv_pkg;

  localparam int N_exposant = 4;
  localparam int N_mantisse = 20;

  localparam int FLOAT_BIAS = 2**(N_exposant-1) - 1;
  localparam int IEEE_BIAS  = 127;

  typedef struct packed {
    logic                  sign;
    logic [N_exposant-1:0] exposant;
    logic [N_mantisse-1:0] mantisse;
  } float;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exposant;
    logic [22:0] mantisse;
  } float_ieee;

  typedef enum logic [1:0] {
    F2I_NORM,
    F2I_ZERO,
    F2I_INF
  } f2i_class_e;

  // Internal bias for an arbitrary exponent width (FLOAT_BIAS is the default-width case).
  function automatic int float_bias(input int n_exp);
    return 2**(n_exp-1) - 1;
  endfunction

endpackage

// File: rtl/float_to_ieee_conv_if.sv
// Stream interface of the float->IEEE output stage: internal floats in, IEEE words out.
// slave = the converter, master = the surrounding coprocessor/LM32 side.
interface float_to_ieee_conv_if
  import float_to_ieee_conv_pkg::*;
#(
  parameter int N_EXPOSANT = N_exposant,
  parameter int N_MANTISSE = N_mantisse
);

  logic                           in_valid;
  logic                           in_ready;
  logic [N_EXPOSANT+N_MANTISSE:0] in_data;
  logic                           out_valid;
  logic                           out_ready;
  float_ieee                      out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/float_to_ieee_conv_core.sv
// Combinational classify-and-rebias of one internal float into IEEE-754 single fields.
module float_to_ieee_conv_core
  import float_to_ieee_conv_pkg::*;
#(
  parameter int N_EXPOSANT = N_exposant,
  parameter int N_MANTISSE = N_mantisse
) (
  input  logic [N_EXPOSANT+N_MANTISSE:0] f_in,
  output float_ieee                      ieee,
  output f2i_class_e                     f_class
);

  localparam int BIAS  = float_bias(N_EXPOSANT);
  localparam int SHIFT = 23 - N_MANTISSE;

  logic                  sign;
  logic [N_EXPOSANT-1:0] e;
  logic [N_MANTISSE-1:0] m;
  logic [7:0]            exp_norm;
  logic [22:0]           mant_norm;

  assign sign = f_in[N_EXPOSANT+N_MANTISSE];
  assign e    = f_in[N_MANTISSE +: N_EXPOSANT];
  assign m    = f_in[N_MANTISSE-1:0];

  // e - BIAS + 127 taken modulo 256; for legal widths it never leaves 1..254.
  assign exp_norm  = 8'(e) + 8'(IEEE_BIAS - BIAS);
  assign mant_norm = 23'(m) << SHIFT;

  always_comb begin
    ieee    = '0;
    f_class = F2I_NORM;
    ieee.sign = sign;
    if (e == '0) begin
      f_class = F2I_ZERO;
    end else if (&e) begin
      f_class       = F2I_INF;
      ieee.exposant = 8'hFF;
    end else begin
      ieee.exposant = exp_norm;
      ieee.mantisse = mant_norm;
    end
  end

endmodule

// File: rtl/float_to_ieee_conv.sv
// Two-stage valid/ready pipeline converting internal floats to IEEE-754 singles.
// Optional sticky zero/inf delivery flags when F2I_FLAGS_EN is defined.
module float_to_ieee_conv
  import float_to_ieee_conv_pkg::*;
#(
  parameter int N_EXPOSANT = N_exposant,
  parameter int N_MANTISSE = N_mantisse,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  float_to_ieee_conv_if.slave bus,
  output logic [CNT_W-1:0]   conv_count
`ifdef F2I_FLAGS_EN
  ,
  output logic               flag_zero,
  output logic               flag_inf
`endif
);

  float_ieee  core_word;
  f2i_class_e core_class;

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [22:0] s1_mant;
  logic        s2_valid;
  float_ieee   out_word;

  logic s1_load;
  logic s2_load;
  logic deliver;

  float_to_ieee_conv_core #(
    .N_EXPOSANT (N_EXPOSANT),
    .N_MANTISSE (N_MANTISSE)
  ) u_core (
    .f_in    (bus.in_data),
    .ieee    (core_word),
    .f_class (core_class)
  );

  // A stage may load when it is empty or the stage after it is draining this cycle.
  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign deliver = s2_valid && bus.out_ready;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = out_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_mant    <= '0;
      s2_valid   <= 1'b0;
      out_word   <= '0;
      conv_count <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign <= core_word.sign;
          s1_exp  <= core_word.exposant;
          s1_mant <= core_word.mantisse;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_word <= '{sign: s1_sign, exposant: s1_exp, mantisse: s1_mant};
        end
      end
      if (deliver) begin
        conv_count <= conv_count + CNT_W'(1);
      end
    end
  end

`ifdef F2I_FLAGS_EN
  f2i_class_e s1_class;
  f2i_class_e s2_class;

  // Class rides alongside the data so the flag reflects the word actually handed over.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_class  <= F2I_NORM;
      s2_class  <= F2I_NORM;
      flag_zero <= 1'b0;
      flag_inf  <= 1'b0;
    end else begin
      if (s1_load && bus.in_valid) begin
        s1_class <= core_class;
      end
      if (s2_load && s1_valid) begin
        s2_class <= s1_class;
      end
      if (deliver && s2_class == F2I_ZERO) begin
        flag_zero <= 1'b1;
      end
      if (deliver && s2_class == F2I_INF) begin
        flag_inf <= 1'b1;
      end
    end
  end
`else
  logic unused_class;
  assign unused_class = ^core_class;
`endif

endmodule

// File: tb/tb_float_to_ieee_conv.sv
// Directed bench for float_to_ieee_conv (N_EXPOSANT=4, N_MANTISSE=20); a CNT_W=4 twin checks wrap.
module tb_float_to_ieee_conv;
  import float_to_ieee_conv_pkg::*;

  localparam int NE = 4;
  localparam int NM = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] conv_count;
  logic [3:0]  conv_count4;
`ifdef F2I_FLAGS_EN
  logic flag_zero, flag_inf, flag_zero4, flag_inf4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  float_to_ieee_conv_if #(.N_EXPOSANT(NE), .N_MANTISSE(NM)) bus ();
  float_to_ieee_conv_if #(.N_EXPOSANT(NE), .N_MANTISSE(NM)) bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.out_ready = bus.out_ready;

  float_to_ieee_conv #(.N_EXPOSANT(NE), .N_MANTISSE(NM), .CNT_W(16)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .conv_count (conv_count)
`ifdef F2I_FLAGS_EN
    ,
    .flag_zero  (flag_zero),
    .flag_inf   (flag_inf)
`endif
  );

  float_to_ieee_conv #(.N_EXPOSANT(NE), .N_MANTISSE(NM), .CNT_W(4)) u_dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus4),
    .conv_count (conv_count4)
`ifdef F2I_FLAGS_EN
    ,
    .flag_zero  (flag_zero4),
    .flag_inf   (flag_inf4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversion for BIAS=7: IEEE exponent = e + 120.
  function automatic logic [31:0] ref_conv(input logic [24:0] f);
    logic       s;
    logic [3:0] e;
    logic [19:0] m;
    s = f[24];
    e = f[23:20];
    m = f[19:0];
    if (e == 4'h0) return {s, 31'h0};
    if (e == 4'hF) return {s, 8'hFF, 23'h0};
    return {s, 8'(e) + 8'd120, m, 3'b000};
  endfunction

  // Scoreboard: every accepted word must come out once, in order, as ref_conv predicts.
  logic [31:0] exp_q[$];
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h expected no output", bus.out_data);
        end else begin
          check("sb_order", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_conv(bus.in_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_count", 32'(conv_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
  endtask

  task automatic send_one(input logic [24:0] d, output logic [31:0] got, output bit ok);
    bit acc;
    acc = 1'b0;
    ok  = 1'b0;
    got = '0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.out_valid) begin
        got = bus.out_data;
        ok  = 1'b1;
      end
      tick();
    end
  endtask

  typedef struct {
    string       name;
    logic [24:0] din;
    logic [31:0] dout;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] got;
    bit          ok;
    logic [24:0] bp_w[3];
    logic [31:0] bp_got[3];
    int          k, n, first, last, nout;
    bit          acc, wrap_seen;
    logic [3:0]  prev4;

    vecs[0] = '{"one",        {1'b0, 4'd7,  20'h00000}, 32'h3F800000};
    vecs[1] = '{"neg_zero",   {1'b1, 4'd0,  20'hABCDE}, 32'h80000000};
    vecs[2] = '{"pos_inf",    {1'b0, 4'hF,  20'h12345}, 32'h7F800000};
    vecs[3] = '{"max_normal", {1'b0, 4'd14, 20'hFFFFF}, 32'h437FFFF8};
    vecs[4] = '{"min_normal", {1'b0, 4'd1,  20'h00000}, 32'h3C800000};
    vecs[5] = '{"neg_2p5",    {1'b1, 4'd8,  20'h40000}, 32'hC0200000};
    vecs[6] = '{"mant_lsb",   {1'b0, 4'd7,  20'h00001}, 32'h3F800008};
    vecs[7] = '{"pos_zero",   {1'b0, 4'd0,  20'hFFFFF}, 32'h00000000};
    vecs[8] = '{"neg_inf",    {1'b1, 4'hF,  20'h00000}, 32'hFF800000};

    do_reset();
`ifdef F2I_FLAGS_EN
    check("rst_flag_zero", 32'(flag_zero), 32'd0);
    check("rst_flag_inf", 32'(flag_inf), 32'd0);
`endif

    // Latency: accepted on edge 0, invisible after edge 1? no -- s1 after edge 0, out_valid after edge 1.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = {1'b0, 4'd7, 20'h0};
    check("lat_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_cycle2_data", bus.out_data, 32'h3F800000);
    tick();
    check("lat_drained", 32'(bus.out_valid), 32'd0);
`ifdef F2I_FLAGS_EN
    check("norm_no_flag_zero", 32'(flag_zero), 32'd0);
    check("norm_no_flag_inf", 32'(flag_inf), 32'd0);
`endif

    for (int i = 0; i < 9; i++) begin
      send_one(vecs[i].din, got, ok);
      check({vecs[i].name, "_seen"}, 32'(ok), 32'd1);
      check(vecs[i].name, got, vecs[i].dout);
    end
    tick();
`ifdef F2I_FLAGS_EN
    check("flag_zero_set", 32'(flag_zero), 32'd1);
    check("flag_inf_set", 32'(flag_inf), 32'd1);
`endif

    // Backpressure: two words fill the pipe, the third waits.
    bp_w[0] = {1'b0, 4'd7, 20'h80000};
    bp_w[1] = {1'b1, 4'd9, 20'h00000};
    bp_w[2] = {1'b0, 4'd3, 20'h40000};
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (k < 3);
      bus.in_data  = bp_w[(k < 3) ? k : 2];
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) k++;
      if (c >= 1) begin
        check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
        check("bp_stall_data", bus.out_data, 32'h3FC00000);
      end
    end
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      bus.in_valid = (k < 3);
      bus.in_data  = bp_w[(k < 3) ? k : 2];
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        bp_got[n] = bus.out_data;
        n++;
      end
      tick();
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    check("bp_delivered", 32'(n), 32'd3);
    check("bp_word0", bp_got[0], 32'h3FC00000);
    check("bp_word1", bp_got[1], 32'hC0800000);
    check("bp_word2", bp_got[2], 32'h3DA00000);

    // Streaming 100 words at full rate; the CNT_W=4 twin must wrap 15 -> 0.
    do_reset();
    bus.out_ready = 1'b1;
    first = -1;
    last  = -1;
    nout  = 0;
    wrap_seen = 1'b0;
    for (int c = 0; c < 110; c++) begin
      bus.in_valid = (c < 100);
      if (c == 0)      bus.in_data = {1'b0, 4'd0, 20'h00000};
      else if (c == 1) bus.in_data = {1'b1, 4'hF, 20'h00000};
      else             bus.in_data = 25'($urandom);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      prev4 = conv_count4;
      tick();
      if (prev4 == 4'd15 && conv_count4 == 4'd0) wrap_seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("stream_outputs", 32'(nout), 32'd100);
    check("stream_first", 32'(first), 32'd2);
    check("stream_back_to_back", 32'(last - first), 32'd99);
    check("stream_count", 32'(conv_count), 32'd100);
    check("stream_count4", 32'(conv_count4), 32'd4);
    check("stream_wrap", 32'(wrap_seen), 32'd1);
`ifdef F2I_FLAGS_EN
    check("stream_flag_zero", 32'(flag_zero), 32'd1);
    check("stream_flag_inf", 32'(flag_inf), 32'd1);
`endif

    // Reset with both stages holding words.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {1'b0, 4'd0, 20'h00000};
    tick();
    bus.in_data   = {1'b0, 4'hF, 20'h00000};
    tick();
    bus.in_valid = 1'b0;
    check("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_full_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", bus.out_data, 32'h0);
    check("mid_rst_count", 32'(conv_count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef F2I_FLAGS_EN
    check("mid_rst_flag_zero", 32'(flag_zero), 32'd0);
    check("mid_rst_flag_inf", 32'(flag_inf), 32'd0);
`endif
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end
    check("mid_count_after", 32'(conv_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
